// File: rtl/smith_waterman_line_serializer_if.sv
// smith_waterman_line_serializer_if
//  Cache-line handshake between smith_waterman_requestor (master) and
//  smith_waterman_line_serializer (slave).
// Signals
//  line_data   master->slave  LINE_W  cache line; byte 0 = bits [7:0]
//  line_valid  master->slave  1       line_data valid this cycle
//  line_ready  slave->master  1       slave line buffer has room for a line
interface smith_waterman_line_serializer_if #(
  parameter int LINE_W = 512
);
  logic [LINE_W-1:0] line_data;
  logic              line_valid;
  logic              line_ready;

  modport master (
    output line_data,
    output line_valid,
    input  line_ready
  );

  modport slave (
    input  line_data,
    input  line_valid,
    output line_ready
  );
endinterface

// File: rtl/smith_waterman_line_serializer.sv
// smith_waterman_line_serializer
//  Turns LINE_W-bit cache lines from the requestor read path into the
//  one-symbol-per-cycle stream consumed by sw_top_affine. Lines are buffered
//  in a FIFO_DEPTH-entry FIFO so reads can run ahead of the systolic array.
// Ports
//  clk        in   sole clock, rising edge
//  rst_n      in   asynchronous active-low reset
//  start      in   1-cycle pulse: begin a stream of count_in bytes
//  count_in   in   stream byte count, sampled on start
//  conf_in    in   1 = configuration stream, sampled on start
//  line       slave side of the cache-line handshake
//  data_out   out  registered stream byte
//  valid_out  out  data_out valid
//  count_out  out  latched count_in, held until the next accepted start
//  conf_out   out  latched conf_in, held until the next accepted start
//  busy       out  1 while streaming
//  done       out  1-cycle pulse once the last byte has been selected
//  overflow   out  sticky: a line was offered while the FIFO was full
module smith_waterman_line_serializer #(
  parameter int LINE_W     = 512,
  parameter int BYTE_W     = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         count_in,
  input  logic                     conf_in,
  smith_waterman_line_serializer_if.slave line,
  output logic [BYTE_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [CNT_W-1:0]         count_out,
  output logic                     conf_out,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int BYTES = LINE_W / BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [LINE_W-1:0]              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [PTR_W:0]                 occ;
  logic                           push, pop, fifo_empty;
  logic [BYTES-1:0][BYTE_W-1:0]   head;
  logic [IDX_W-1:0]               idx;
  logic [CNT_W-1:0]               remaining;
  logic                           zero_done;
  logic                           emit, load, last_byte;

  // Ready depends on occupancy alone, so a same-cycle pop never frees a slot
  // early; this keeps line_ready free of any path from the FSM.
  assign line.line_ready = (occ != FULL_OCC);
  assign fifo_empty      = (occ == '0);
  assign push            = line.line_valid && line.line_ready;
  assign head            = mem[rd_ptr];
  assign last_byte       = (remaining == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. start is only honoured in IDLE; a zero-length start
  // stays in IDLE and is answered by the zero_done pulse instead.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (load) state_nxt = S_STREAM;
      S_STREAM: if (emit && last_byte) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes. A byte is emitted on every STREAM cycle
  // with a line available; the head is popped on its last byte or on the
  // stream's last byte, which discards the unused tail of a partial line.
  always_comb begin
    busy = 1'b0;
    done = zero_done;
    emit = 1'b0;
    load = 1'b0;
    pop  = 1'b0;
    case (state)
      S_IDLE:   load = start && (count_in != '0);
      S_STREAM: begin
        busy = 1'b1;
        emit = !fifo_empty;
        pop  = emit && ((idx == LAST_IDX) || last_byte);
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // Line storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= line.line_data;
  end

  // FIFO pointers and occupancy. Push and pop together leave occupancy as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Stream datapath: registered byte output, byte index, remaining count,
  // latched stream descriptor and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      idx       <= '0;
      remaining <= '0;
      count_out <= '0;
      conf_out  <= 1'b0;
      zero_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= emit;
      zero_done <= (state == S_IDLE) && start && (count_in == '0);
      if (emit) begin
        data_out <= head[idx];
        if (remaining != '0) remaining <= remaining - 1'b1;
        idx <= pop ? '0 : idx + 1'b1;
      end
      if (load) begin
        count_out <= count_in;
        conf_out  <= conf_in;
        remaining <= count_in;
        idx       <= '0;
      end
      if (line.line_valid && !line.line_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smith_waterman_line_serializer.sv
// tb_smith_waterman_line_serializer
//  Directed bench for smith_waterman_line_serializer: prefetch, multi-line
//  and partial-line streams, back-to-back lines, overflow, asynchronous reset
//  mid-stream, zero-length start and ignored starts while busy or done.
module tb_smith_waterman_line_serializer;

  localparam int LINE_W = 512;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  count_in = '0;
  logic              conf_in = 1'b0;
  logic [BYTE_W-1:0] data_out;
  logic              valid_out;
  logic [CNT_W-1:0]  count_out;
  logic              conf_out;
  logic              busy;
  logic              done;
  logic              overflow;

  int n_asserts = 0;
  int n_fail    = 0;

  smith_waterman_line_serializer_if #(.LINE_W(LINE_W)) line_bus ();

  smith_waterman_line_serializer #(
    .LINE_W(LINE_W), .BYTE_W(BYTE_W), .FIFO_DEPTH(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in),
    .conf_in(conf_in), .line(line_bus.slave), .data_out(data_out),
    .valid_out(valid_out), .count_out(count_out), .conf_out(conf_out),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge: outputs are settled there
  // and new inputs set up for the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mkLine(input logic [7:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / BYTE_W; i++) l[i*8 +: 8] = base + 8'(i);
    return l;
  endfunction

  task automatic pushLine(input logic [7:0] base);
    line_bus.line_data  = mkLine(base);
    line_bus.line_valid = 1'b1;
    tick();
    line_bus.line_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic s, input int cnt, input logic cf);
    start    = s;
    count_in = CNT_W'(cnt);
    conf_in  = cf;
  endtask

  // Check n_check consecutive bytes of a total-byte stream whose first line
  // starts at base1 and second at base2; done and !busy only on the last byte.
  task automatic checkBytes(input int n_check, input int total,
                            input logic [7:0] base1, input logic [7:0] base2);
    logic [7:0] exp_b;
    for (int i = 0; i < n_check; i++) begin
      tick();
      exp_b = (i < 64) ? base1 + 8'(i) : base2 + 8'(i - 64);
      checkOutput($sformatf("valid[%0d]", i), 64'(valid_out), 64'(1));
      checkOutput($sformatf("data[%0d]", i), 64'(data_out), 64'(exp_b));
      checkOutput($sformatf("done[%0d]", i), 64'(done), 64'(i == total - 1));
      checkOutput($sformatf("busy[%0d]", i), 64'(busy), 64'(i != total - 1));
    end
  endtask

  initial begin
    line_bus.line_data  = '0;
    line_bus.line_valid = 1'b0;

    // Reset state
    tick();
    checkOutput("rst_valid", 64'(valid_out), 64'(0));
    checkOutput("rst_data", 64'(data_out), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_ovf", 64'(overflow), 64'(0));
    checkOutput("rst_ready", 64'(line_bus.line_ready), 64'(1));
    checkOutput("rst_count", 64'(count_out), 64'(0));
    rst_n = 1'b1;
    tick();

    // 1: one full line, 64 bytes
    $display("[TB] single line, count 64");
    pushLine(8'h00);
    applyStimulus(1'b1, 64, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t1_busy", 64'(busy), 64'(1));
    checkOutput("t1_valid0", 64'(valid_out), 64'(0));
    checkOutput("t1_count", 64'(count_out), 64'(64));
    checkBytes(64, 64, 8'h00, 8'h00);
    tick();
    checkOutput("t1_valid_end", 64'(valid_out), 64'(0));
    checkOutput("t1_done_end", 64'(done), 64'(0));
    checkOutput("t1_ready_end", 64'(line_bus.line_ready), 64'(1));

    // 2: count 70 across two prefetched lines, second line partly discarded
    $display("[TB] two lines, count 70");
    pushLine(8'h40);
    checkOutput("t2_ready1", 64'(line_bus.line_ready), 64'(1));
    pushLine(8'h80);
    checkOutput("t2_ready2", 64'(line_bus.line_ready), 64'(0));
    applyStimulus(1'b1, 70, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t2_conf", 64'(conf_out), 64'(1));
    checkBytes(70, 70, 8'h40, 8'h80);
    tick();
    checkOutput("t2_valid_end", 64'(valid_out), 64'(0));

    // 3: fill FIFO in IDLE, count 128, first byte 2 clk after start
    $display("[TB] prefetch, count 128");
    pushLine(8'h10);
    checkOutput("t3_ready1", 64'(line_bus.line_ready), 64'(1));
    pushLine(8'h50);
    checkOutput("t3_ready2", 64'(line_bus.line_ready), 64'(0));
    applyStimulus(1'b1, 128, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t3_valid_s1", 64'(valid_out), 64'(0));
    checkBytes(128, 128, 8'h10, 8'h50);
    tick();
    checkOutput("t3_valid_end", 64'(valid_out), 64'(0));

    // 4: overflow when pushing into a full FIFO
    $display("[TB] overflow");
    pushLine(8'h20);
    pushLine(8'h60);
    checkOutput("t4_ready", 64'(line_bus.line_ready), 64'(0));
    checkOutput("t4_ovf_pre", 64'(overflow), 64'(0));
    pushLine(8'hA0);
    checkOutput("t4_ovf_set", 64'(overflow), 64'(1));
    tick();
    checkOutput("t4_ovf_hold", 64'(overflow), 64'(1));
    applyStimulus(1'b1, 128, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkBytes(128, 128, 8'h20, 8'h60);
    tick();
    checkOutput("t4_ovf_end", 64'(overflow), 64'(1));
    checkOutput("t4_ready_end", 64'(line_bus.line_ready), 64'(1));

    // 5: asynchronous reset at byte 30 of 64
    $display("[TB] reset mid-stream");
    pushLine(8'h33);
    applyStimulus(1'b1, 64, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkBytes(30, 64, 8'h33, 8'h00);
    checkOutput("t5_conf_pre", 64'(conf_out), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_valid", 64'(valid_out), 64'(0));
    checkOutput("t5_data", 64'(data_out), 64'(0));
    checkOutput("t5_busy", 64'(busy), 64'(0));
    checkOutput("t5_done", 64'(done), 64'(0));
    checkOutput("t5_ovf", 64'(overflow), 64'(0));
    checkOutput("t5_count", 64'(count_out), 64'(0));
    checkOutput("t5_conf", 64'(conf_out), 64'(0));
    checkOutput("t5_ready", 64'(line_bus.line_ready), 64'(1));
    tick();
    rst_n = 1'b1;
    tick();
    pushLine(8'hC0);
    applyStimulus(1'b1, 5, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t5_count_new", 64'(count_out), 64'(5));
    checkBytes(5, 5, 8'hC0, 8'h00);
    tick();
    checkOutput("t5_valid_end", 64'(valid_out), 64'(0));

    // 6: zero-length start, then starts ignored in STREAM and DONE
    $display("[TB] zero count and ignored starts");
    applyStimulus(1'b1, 0, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t6_zdone", 64'(done), 64'(1));
    checkOutput("t6_zvalid", 64'(valid_out), 64'(0));
    checkOutput("t6_zbusy", 64'(busy), 64'(0));
    checkOutput("t6_zcount", 64'(count_out), 64'(5));
    checkOutput("t6_zconf", 64'(conf_out), 64'(0));
    tick();
    checkOutput("t6_zdone_off", 64'(done), 64'(0));
    checkOutput("t6_zvalid2", 64'(valid_out), 64'(0));
    pushLine(8'h11);
    applyStimulus(1'b1, 3, 1'b0);
    tick();
    applyStimulus(1'b1, 5, 1'b1);
    checkOutput("t6_busy", 64'(busy), 64'(1));
    checkOutput("t6_count", 64'(count_out), 64'(3));
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t6_b0_valid", 64'(valid_out), 64'(1));
    checkOutput("t6_b0_data", 64'(data_out), 64'(8'h11));
    checkOutput("t6_count_hold", 64'(count_out), 64'(3));
    checkOutput("t6_conf_hold", 64'(conf_out), 64'(0));
    tick();
    checkOutput("t6_b1_data", 64'(data_out), 64'(8'h12));
    checkOutput("t6_b1_done", 64'(done), 64'(0));
    tick();
    checkOutput("t6_b2_data", 64'(data_out), 64'(8'h13));
    checkOutput("t6_b2_done", 64'(done), 64'(1));
    applyStimulus(1'b1, 7, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("t6_dstart_busy", 64'(busy), 64'(0));
    checkOutput("t6_dstart_done", 64'(done), 64'(0));
    checkOutput("t6_dstart_count", 64'(count_out), 64'(3));
    tick();
    checkOutput("t6_idle_busy", 64'(busy), 64'(0));
    checkOutput("t6_idle_valid", 64'(valid_out), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
